// File: rtl/snn_spike_out_packetizer.sv
// Spike-out packetizer: timestep-tagged spike and end-of-step packets through a FWFT FIFO.
// Define SNN_PKT_DROP_CNT_EN to build the saturating dropped-spike counter.
module snn_spike_out_packetizer #(
    parameter int ADDR_WIDTH = 14,
    parameter int TS_WIDTH   = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DROP_WIDTH = 16,
    parameter int PKT_WIDTH  = 1 + TS_WIDTH + ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_spike_valid,
    input  logic [ADDR_WIDTH-1:0] i_spike_addr,
    input  logic                  i_step_done,
    output logic                  o_pkt_valid,
    input  logic                  i_pkt_ready,
    output logic [PKT_WIDTH-1:0]  o_pkt_data,
    output logic                  o_fifo_full,
    output logic                  o_eos_lost,
    output logic [TS_WIDTH-1:0]   o_ts,
    input  logic                  i_clear_stats,
    output logic [DROP_WIDTH-1:0] o_drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PKT_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [ADDR_WIDTH-1:0] step_count;
    logic [ADDR_WIDTH-1:0] step_count_incl;
    logic                  spike_wr;
    logic                  eos_wr;
    logic                  pop;

    // The last slot is reserved so an EOS can always follow a burst of spikes.
    always_comb begin
        spike_wr = i_spike_valid && (count < CNT_W'(FIFO_DEPTH - 1));
        eos_wr   = i_step_done && ((count + CNT_W'(spike_wr)) < CNT_W'(FIFO_DEPTH));
        pop      = (count != '0) && i_pkt_ready;
        step_count_incl = step_count;
        if (i_spike_valid && (step_count != '1))
            step_count_incl = step_count + ADDR_WIDTH'(1);
    end

    assign o_pkt_valid = (count != '0);
    assign o_pkt_data  = mem[rd_ptr];
    assign o_fifo_full = (count >= CNT_W'(FIFO_DEPTH - 1));

    // NOTE: storage has no reset; o_pkt_valid masks stale contents, and leaving it
    // out of reset lets the array map onto plain flops or RAM without a clear path.
    always_ff @(posedge clk) begin
        if (spike_wr)
            mem[wr_ptr] <= {1'b0, o_ts, i_spike_addr};
        if (eos_wr)
            mem[wr_ptr + PTR_W'(spike_wr)] <= {1'b1, o_ts, step_count_incl};
    end

    // NOTE: all state uses non-blocking assignments so every register samples the
    // pre-edge values, matching the combinational admission decisions above.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_ts       <= '0;
            step_count <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(spike_wr) + PTR_W'(eos_wr);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(spike_wr) + CNT_W'(eos_wr) - CNT_W'(pop);
            if (i_step_done) begin
                o_ts       <= o_ts + TS_WIDTH'(1);
                step_count <= '0;
            end else begin
                step_count <= step_count_incl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear_stats)
            o_eos_lost <= 1'b0;
        else if (i_step_done && !eos_wr)
            o_eos_lost <= 1'b1;
    end

`ifdef SNN_PKT_DROP_CNT_EN
    logic dropped;
    assign dropped = i_spike_valid && !spike_wr;

    // A drop coinciding with a clear is discarded: the clear wins.
    always_ff @(posedge clk) begin
        if (rst || i_clear_stats)
            o_drop_count <= '0;
        else if (dropped && (o_drop_count != '1))
            o_drop_count <= o_drop_count + DROP_WIDTH'(1);
    end
`else
    assign o_drop_count = '0;
`endif

endmodule

// File: tb/tb_snn_spike_out_packetizer.sv
// Bench for snn_spike_out_packetizer: directed scenarios plus randomized traffic vs a queue model.
module tb_snn_spike_out_packetizer;

    localparam int AW = 14;
    localparam int TW = 8;
    localparam int D  = 16;
    localparam int DW = 16;
    localparam int PW = 1 + TW + AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          spike_valid;
    logic [AW-1:0] spike_addr;
    logic          step_done;
    logic          pkt_valid;
    logic          pkt_ready;
    logic [PW-1:0] pkt_data;
    logic          fifo_full;
    logic          eos_lost;
    logic [TW-1:0] ts;
    logic          clear_stats;
    logic [DW-1:0] drop_count;

    snn_spike_out_packetizer #(
        .ADDR_WIDTH(AW), .TS_WIDTH(TW), .FIFO_DEPTH(D), .DROP_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_spike_valid(spike_valid), .i_spike_addr(spike_addr),
        .i_step_done(step_done),
        .o_pkt_valid(pkt_valid), .i_pkt_ready(pkt_ready), .o_pkt_data(pkt_data),
        .o_fifo_full(fifo_full), .o_eos_lost(eos_lost), .o_ts(ts),
        .i_clear_stats(clear_stats), .o_drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: packet queue plus scalar stats.
    logic [PW-1:0] q[$];
    logic [TW-1:0] m_ts;
    int            m_step;
    int            m_drop;
    bit            m_lost;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] pkt(input bit eos, input logic [TW-1:0] t, input int pay);
        logic [AW-1:0] p;
        p = pay[AW-1:0];
        return {eos, t, p};
    endfunction

    task automatic check_outputs();
        check("valid", 64'(pkt_valid), 64'(q.size() != 0));
        if (q.size() != 0)
            check("data", 64'(pkt_data), 64'(q[0]));
        check("full", 64'(fifo_full), 64'(q.size() >= D - 1));
        check("ts", 64'(ts), 64'(m_ts));
        check("drop", 64'(drop_count), 64'(m_drop));
        check("lost", 64'(eos_lost), 64'(m_lost));
    endtask

    // One clock: drive, compare pre-edge outputs, advance model, take the edge.
    task automatic step(input bit s, input int a, input bit d, input bit r, input bit c);
        int  n;
        bit  sw, ew;
        int  step_incl;
        spike_valid = s;
        spike_addr  = a[AW-1:0];
        step_done   = d;
        pkt_ready   = r;
        clear_stats = c;
        #1;
        check_outputs();
        n  = q.size();
        sw = s && (n < D - 1);
        ew = d && ((n + int'(sw)) < D);
        step_incl = (s && m_step < (1 << AW) - 1) ? m_step + 1 : m_step;
        if (n != 0 && r)
            void'(q.pop_front());
        if (sw) q.push_back(pkt(1'b0, m_ts, a));
        if (ew) q.push_back(pkt(1'b1, m_ts, step_incl));
`ifdef SNN_PKT_DROP_CNT_EN
        if (c) m_drop = 0;
        else if (s && !sw && m_drop < (1 << DW) - 1) m_drop++;
`endif
        if (c) m_lost = 0;
        else if (d && !ew) m_lost = 1;
        if (d) begin
            m_ts   = m_ts + 1'b1;
            m_step = 0;
        end else begin
            m_step = step_incl;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        spike_valid = 0; step_done = 0; pkt_ready = 0; clear_stats = 0; spike_addr = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_ts = '0; m_step = 0; m_drop = 0; m_lost = 0;
    endtask

    // Checks the head packet against an explicit value, then pops it.
    task automatic expect_pop(input string tag, input logic [PW-1:0] exp);
        #1;
        check({tag, "_valid"}, 64'(pkt_valid), 64'd1);
        check(tag, 64'(pkt_data), 64'(exp));
        step(0, 0, 0, 1, 0);
    endtask

    initial begin
        do_reset();
        check_outputs();

        // T1: three spikes then a done.
        step(1, 5, 0, 0, 0);
        step(1, 9, 0, 0, 0);
        step(1, 12, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("t1_ts", 64'(ts), 64'd1);
        expect_pop("t1_p0", pkt(0, 0, 5));
        expect_pop("t1_p1", pkt(0, 0, 9));
        expect_pop("t1_p2", pkt(0, 0, 12));
        expect_pop("t1_eos", pkt(1, 0, 3));
        check("t1_empty", 64'(pkt_valid), 64'd0);

        // T2: overflow with 20 spikes, EOS lands in the reserved slot.
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 100 + i, 0, 0, 0);
        step(0, 0, 1, 0, 0);
`ifdef SNN_PKT_DROP_CNT_EN
        check("t2_drop", 64'(drop_count), 64'd5);
`else
        check("t2_drop", 64'(drop_count), 64'd0);
`endif
        check("t2_full", 64'(fifo_full), 64'd1);
        check("t2_lost", 64'(eos_lost), 64'd0);
        for (int i = 0; i < 15; i++) expect_pop("t2_spk", pkt(0, 0, 100 + i));
        expect_pop("t2_eos", pkt(1, 0, 20));
        check("t2_empty", 64'(pkt_valid), 64'd0);

        // T3: spike and done in the same cycle.
        step(1, 7, 1, 0, 0);
        check("t3_ts", 64'(ts), 64'd2);
        expect_pop("t3_spk", pkt(0, 1, 7));
        expect_pop("t3_eos", pkt(1, 1, 1));

        // T4: push during pop keeps occupancy at one.
        step(1, 33, 0, 0, 0);
        step(1, 44, 0, 1, 0);
        check("t4_valid", 64'(pkt_valid), 64'd1);
        expect_pop("t4_next", pkt(0, 2, 44));

        // T5: 256 empty steps wrap the tag.
        do_reset();
        for (int i = 0; i < 256; i++) step(0, 0, 1, 1, 0);
        check("t5_ts_wrap", 64'(ts), 64'd0);
        step(0, 0, 0, 1, 0);

        // T6: reset with entries queued.
        for (int i = 0; i < 5; i++) step(1, i, 0, 0, 0);
        do_reset();
        check("t6_valid", 64'(pkt_valid), 64'd0);
        check("t6_ts", 64'(ts), 64'd0);
        check("t6_drop", 64'(drop_count), 64'd0);

        // EOS loss when FIFO is completely full, then clear.
        for (int i = 0; i < 15; i++) step(1, i, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        check("lost_set", 64'(eos_lost), 64'd1);
        step(0, 0, 0, 0, 1);
        check("lost_clr", 64'(eos_lost), 64'd0);

        // Randomized traffic in phases of varying consumer pressure.
        do_reset();
        for (int phase = 0; phase < 8; phase++) begin
            int rdy_pct;
            rdy_pct = (phase % 4) * 30;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 399) == 0) begin
                    do_reset();
                end else begin
                    step($urandom_range(0, 99) < 60,
                         int'($urandom_range(0, (1 << AW) - 1)),
                         $urandom_range(0, 99) < 8,
                         $urandom_range(0, 99) < rdy_pct,
                         $urandom_range(0, 99) < 3);
                end
            end
        end
        while (q.size() != 0) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
